i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h42, 7-bit I2C target address this block answers to.
REQ-002 clk  input  1  system clock (50 MHz); all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 scl_i  input  1  raw SCL from bus pin, asynchronous.
REQ-005 sda_i  input  1  raw SDA from bus pin, asynchronous.
REQ-006 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-007 reg_addr  output  8  current register pointer.
REQ-008 wr_en  output  1  one-cycle strobe; write wr_data to reg_addr.
REQ-009 wr_data  output  8  byte received from controller.
REQ-010 rd_req  output  1  one-cycle strobe; requests byte at reg_addr.
REQ-011 rd_data  input  8  read byte; sampled exactly 1 cycle after rd_req.
REQ-012 busy  output  1  high from START detection until STOP or reset.

Function
REQ-013 scl_i/sda_i SHALL pass through a 2-flop synchronizer; edges detected on synchronized values.
REQ-014 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high.
REQ-015 Bits sampled on SCL rising edge, MSB first; sda_oe changes only on the cycle after an SCL falling edge.
REQ-016 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-017 IDLE -> ADDR on START; any state -> ADDR on repeated START; any state -> IDLE on STOP.
REQ-018 ADDR: after 8 bits, address match -> ADDR_ACK (sda_oe=1 for 9th clock); mismatch -> IGNORE (no ACK, no strobes until START/STOP).
REQ-019 ADDR_ACK, R/W=0 -> PTR after first write phase of transaction, WDATA otherwise; R/W=1 -> RDATA.
REQ-020 PTR: received byte loaded into reg_addr at 8th rising edge; ACK; -> WDATA.
REQ-021 WDATA: wr_en pulses once, wr_data valid, at 8th rising edge; ACK; reg_addr increments after the ACK clock.
REQ-022 RDATA: rd_req pulses on the SCL falling edge ending the preceding ACK; rd_data captured next cycle and shifted out, first bit driven before next SCL rise.
REQ-023 RDATA_ACK: controller ACK (SDA low) -> increment reg_addr, -> RDATA; NACK -> release SDA, wait for START/STOP.
REQ-024 reg_addr SHALL wrap 8'hFF -> 8'h00; reg_addr retained across repeated START and STOP.
REQ-025 sda_oe SHALL be 0 within 1 cycle of STOP or START detection.
REQ-026 STOP mid-byte discards the partial byte; no wr_en for it.
REQ-027 Supported bus timing: SCL high and low phases each >= 8 clk cycles.

Reset
REQ-028 On rst: state IDLE, sda_oe=0, wr_en=0, rd_req=0, busy=0, reg_addr=8'h00, wr_data=8'h00, bit counter and shift register cleared; synchronizers set to 1 (idle bus).
REQ-029 rst mid-transaction aborts; block ignores bus until the next START.

Configuration
REQ-030 Macro I2C_TARGET_GLITCH_FILTER_EN defined: synced SCL and SDA each pass a 3-sample majority filter (2 extra cycles latency); pulses <= 1 clk ignored.
REQ-031 Macro I2C_TARGET_GLITCH_FILTER_EN undefined: no filter; synchronizer output used directly.

Verification
REQ-032 START, 0x84 (addr 0x42,W), ptr 0x10, data 0xA5, STOP -> 3 ACKs; exactly one wr_en with reg_addr=0x10, wr_data=0xA5; reg_addr=0x11 after.
REQ-033 Write ptr 0x20, repeated START, 0x85, read 2 bytes (ACK, NACK), rd_data model returns 0x3C,0xC3 -> SDA carries 0x3C then 0xC3; 2 rd_req pulses; reg_addr=0x22.
REQ-034 START, 0x90 (addr 0x48) + 2 bytes -> sda_oe stays 0; no wr_en/rd_req.
REQ-035 Write ptr 0xFF, data 0x01, 0x02 -> wr_en at 0xFF then 0x00; reg_addr=0x01.
REQ-036 STOP after 4 data bits -> no wr_en; state IDLE; busy=0 next cycle.
REQ-037 With I2C_TARGET_GLITCH_FILTER_EN: 1-cycle SCL low glitch mid-bit -> no extra bit counted; transfer of REQ-032 unaffected.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target (7-bit address) with register-pointer write and sequential read access.
// Optional SCL/SDA 3-sample majority glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } state_e;

    state_e     state_q, state_d;
    logic       scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_s, sda_s;
    logic       busy_q, busy_d;
    logic       sda_oe_q, sda_oe_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_req_q, rd_req_d;
    logic       first_wr_q, first_wr_d;
    logic       ack_q, ack_d;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;
    logic       addr_match;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_flt_q, sda_flt_q;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Majority vote over the last three synchronized samples; single-cycle pulses vanish.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_flt_q  <= 1'b1;
            sda_flt_q  <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_s2_q};
            sda_hist_q <= {sda_hist_q[0], sda_s2_q};
            scl_flt_q  <= maj3({scl_hist_q, scl_s2_q});
            sda_flt_q  <= maj3({sda_hist_q, sda_s2_q});
        end
    end

    assign scl_s = scl_flt_q;
    assign sda_s = sda_flt_q;
`else
    assign scl_s = scl_s2_q;
    assign sda_s = sda_s2_q;
`endif

    assign scl_rise   = scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s & scl_prev_q;
    assign start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte    = {shift_q[6:0], sda_s};
    assign addr_match = (shift_q[7:1] == TARGET_ADDR);

    // State register, synchronizers (idle-bus reset value) and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            reg_addr_q <= 8'h00;
            wr_data_q  <= 8'h00;
            wr_en_q    <= 1'b0;
            rd_req_q   <= 1'b0;
            first_wr_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_s1_q   <= scl_i;
            scl_s2_q   <= scl_s1_q;
            sda_s1_q   <= sda_i;
            sda_s2_q   <= sda_s1_q;
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            busy_q     <= busy_d;
            sda_oe_q   <= sda_oe_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            rd_req_q   <= rd_req_d;
            first_wr_q <= first_wr_d;
            ack_q      <= ack_d;
        end
    end

    // Next-state logic; byte states hand over to their ACK state on the 8th SCL fall.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = ST_ADDR;
        end else if (stop_det) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_fall && bit_cnt_q == 4'd8) state_d = addr_match ? ST_ADDR_ACK : ST_IGNORE;
                    else state_d = ST_ADDR;
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) state_d = shift_q[0] ? ST_RDATA : (first_wr_q ? ST_PTR : ST_WDATA);
                    else state_d = ST_ADDR_ACK;
                end
                ST_PTR: begin
                    if (scl_fall && bit_cnt_q == 4'd8) state_d = ST_PTR_ACK;
                    else state_d = ST_PTR;
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) state_d = ST_WDATA;
                    else state_d = state_q;
                end
                ST_WDATA: begin
                    if (scl_fall && bit_cnt_q == 4'd8) state_d = ST_WDATA_ACK;
                    else state_d = ST_WDATA;
                end
                ST_RDATA: begin
                    if (scl_fall && bit_cnt_q == 4'd8) state_d = ST_RDATA_ACK;
                    else state_d = ST_RDATA;
                end
                ST_RDATA_ACK: begin
                    if (scl_fall) state_d = ack_q ? ST_RDATA : ST_IGNORE;
                    else state_d = ST_RDATA_ACK;
                end
                ST_IDLE:   state_d = ST_IDLE;
                ST_IGNORE: state_d = ST_IGNORE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Output and datapath logic: shifting, strobes, SDA drive and pointer updates.
    always_comb begin
        busy_d     = busy_q;
        sda_oe_d   = sda_oe_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        rd_req_d   = 1'b0;
        first_wr_d = first_wr_q;
        ack_d      = ack_q;
        if (start_det) begin
            busy_d     = 1'b1;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = 4'd0;
            shift_d    = 8'h00;
            first_wr_d = ~busy_q | first_wr_q;
        end else if (stop_det) begin
            busy_d     = 1'b0;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = 4'd0;
            shift_d    = 8'h00;
            first_wr_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && state_q == ST_PTR) begin
                            reg_addr_d = rx_byte;
                            first_wr_d = 1'b0;
                        end else if (bit_cnt_q == 4'd7 && state_q == ST_WDATA) begin
                            wr_en_d   = 1'b1;
                            wr_data_d = rx_byte;
                        end else begin
                            wr_en_d = 1'b0;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = (state_q != ST_ADDR) || addr_match;
                    end else begin
                        sda_oe_d = 1'b0;
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        rd_req_d  = (state_q == ST_ADDR_ACK) && shift_q[0];
                        if (state_q == ST_WDATA_ACK) reg_addr_d = reg_addr_q + 8'd1;
                        else reg_addr_d = reg_addr_q;
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                ST_RDATA: begin
                    // rd_data is valid the cycle after the rd_req strobe.
                    if (rd_req_q) begin
                        shift_d  = rd_data;
                        sda_oe_d = ~rd_data[7];
                    end else if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        ack_d = ~sda_s;
                    end else if (scl_fall) begin
                        reg_addr_d = reg_addr_q + 8'd1;
                        bit_cnt_d  = 4'd0;
                        rd_req_d   = ack_q;
                    end else begin
                        ack_d = ack_q;
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign reg_addr = reg_addr_q;
    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign rd_req   = rd_req_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged controller on a wired-AND SDA, a
// read-data model that answers rd_req, and monitors logging strobes.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_tb = 1'b1;
    logic       sda_tb = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_data = 8'h00;
    logic       busy;
    logic       glitch_on = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int rd_cnt  = 0;
    int oe_cnt  = 0;
    logic [7:0] wr_addr_log [0:15];
    logic [7:0] wr_data_log [0:15];
    logic [7:0] rd_addr_log [0:3];

    assign sda_bus = sda_tb & ~sda_oe;

    i2c_target #(.TARGET_ADDR(7'h42)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_tb),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .reg_addr (reg_addr),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    // Strobe monitors and register-file model (returns 0x3C then 0xC3).
    always @(negedge clk) begin
        if (wr_en) begin
            wr_addr_log[wr_cnt[3:0]] = reg_addr;
            wr_data_log[wr_cnt[3:0]] = wr_data;
            wr_cnt = wr_cnt + 1;
        end
        if (rd_req) begin
            rd_addr_log[rd_cnt[1:0]] = reg_addr;
            rd_data = rd_cnt[0] ? 8'hC3 : 8'h3C;
            rd_cnt = rd_cnt + 1;
        end
        if (sda_oe) oe_cnt = oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period: drive SDA in the low phase, sample the bus mid-high.
    task automatic clk_bit(input logic drv, output logic smp);
        wait_clk(3);
        sda_tb = drv;
        wait_clk(7);
        scl_tb = 1'b1;
        if (glitch_on) begin
            wait_clk(3);
            scl_tb = 1'b0;
            wait_clk(1);
            scl_tb = 1'b1;
            wait_clk(3);
        end else begin
            wait_clk(7);
        end
        smp = sda_bus;
        wait_clk(3);
        scl_tb = 1'b0;
    endtask

    task automatic i2c_start();
        sda_tb = 1'b1;
        wait_clk(5);
        scl_tb = 1'b1;
        wait_clk(8);
        sda_tb = 1'b0;
        wait_clk(8);
        scl_tb = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(3);
        sda_tb = 1'b0;
        wait_clk(7);
        scl_tb = 1'b1;
        wait_clk(6);
        sda_tb = 1'b1;
        wait_clk(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(~ack, s);
    endtask

    initial begin
        logic       a;
        logic       s;
        logic [7:0] d;
        int         wb;
        int         rb;
        int         ob;

        wait_clk(5);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_reg_addr", {24'd0, reg_addr}, 32'h00);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_rd_req", {31'd0, rd_req}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'h00);
        rst = 1'b0;
        wait_clk(5);

        // Pointer + single data write.
        wb = wr_cnt;
        i2c_start();
        write_byte(8'h84, a);
        check("w1_addr_ack", {31'd0, a}, 32'd1);
        check("w1_busy", {31'd0, busy}, 32'd1);
        write_byte(8'h10, a);
        check("w1_ptr_ack", {31'd0, a}, 32'd1);
        write_byte(8'hA5, a);
        check("w1_data_ack", {31'd0, a}, 32'd1);
        i2c_stop();
        check("w1_wr_count", wr_cnt - wb, 32'd1);
        check("w1_wr_addr", {24'd0, wr_addr_log[wb[3:0]]}, 32'h10);
        check("w1_wr_data", {24'd0, wr_data_log[wb[3:0]]}, 32'hA5);
        check("w1_reg_addr", {24'd0, reg_addr}, 32'h11);
        check("w1_busy_after", {31'd0, busy}, 32'd0);

        // Pointer write, repeated START, two-byte read.
        rb = rd_cnt;
        i2c_start();
        write_byte(8'h84, a);
        check("r_addr_ack", {31'd0, a}, 32'd1);
        write_byte(8'h20, a);
        check("r_ptr_ack", {31'd0, a}, 32'd1);
        i2c_start();
        write_byte(8'h85, a);
        check("r_raddr_ack", {31'd0, a}, 32'd1);
        read_byte(1'b1, d);
        check("r_byte0", {24'd0, d}, 32'h3C);
        read_byte(1'b0, d);
        check("r_byte1", {24'd0, d}, 32'hC3);
        i2c_stop();
        check("r_rd_count", rd_cnt - rb, 32'd2);
        check("r_rd_addr0", {24'd0, rd_addr_log[0]}, 32'h20);
        check("r_rd_addr1", {24'd0, rd_addr_log[1]}, 32'h21);
        check("r_reg_addr", {24'd0, reg_addr}, 32'h22);

        // Foreign address: no ACK, no strobes.
        wb = wr_cnt; rb = rd_cnt; ob = oe_cnt;
        i2c_start();
        write_byte(8'h90, a);
        check("x_addr_nack", {31'd0, a}, 32'd0);
        write_byte(8'h11, a);
        write_byte(8'h22, a);
        check("x_data_nack", {31'd0, a}, 32'd0);
        i2c_stop();
        check("x_oe_cycles", oe_cnt - ob, 32'd0);
        check("x_wr_count", wr_cnt - wb, 32'd0);
        check("x_rd_count", rd_cnt - rb, 32'd0);
        check("x_reg_addr", {24'd0, reg_addr}, 32'h22);

        // Pointer wrap 0xFF -> 0x00.
        wb = wr_cnt;
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'hFF, a);
        write_byte(8'h01, a);
        write_byte(8'h02, a);
        check("wrap_last_ack", {31'd0, a}, 32'd1);
        i2c_stop();
        check("wrap_wr_count", wr_cnt - wb, 32'd2);
        check("wrap_addr0", {24'd0, wr_addr_log[wb[3:0]]}, 32'hFF);
        check("wrap_data0", {24'd0, wr_data_log[wb[3:0]]}, 32'h01);
        check("wrap_addr1", {24'd0, wr_addr_log[(wb + 1) % 16]}, 32'h00);
        check("wrap_data1", {24'd0, wr_data_log[(wb + 1) % 16]}, 32'h02);
        check("wrap_reg_addr", {24'd0, reg_addr}, 32'h01);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // Same write as the first transfer, with a 1-cycle SCL low glitch in every high phase.
        wb = wr_cnt;
        glitch_on = 1'b1;
        i2c_start();
        write_byte(8'h84, a);
        check("g_addr_ack", {31'd0, a}, 32'd1);
        write_byte(8'h10, a);
        write_byte(8'hA5, a);
        check("g_data_ack", {31'd0, a}, 32'd1);
        glitch_on = 1'b0;
        i2c_stop();
        check("g_wr_count", wr_cnt - wb, 32'd1);
        check("g_wr_addr", {24'd0, wr_addr_log[wb[3:0]]}, 32'h10);
        check("g_wr_data", {24'd0, wr_data_log[wb[3:0]]}, 32'hA5);
        check("g_reg_addr", {24'd0, reg_addr}, 32'h11);
`endif

        // STOP after four data bits discards the partial byte.
        wb = wr_cnt;
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h30, a);
        clk_bit(1'b1, s);
        clk_bit(1'b0, s);
        clk_bit(1'b1, s);
        clk_bit(1'b0, s);
        i2c_stop();
        check("p_wr_count", wr_cnt - wb, 32'd0);
        check("p_busy", {31'd0, busy}, 32'd0);
        check("p_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("p_reg_addr", {24'd0, reg_addr}, 32'h30);

        // Reset mid-transaction: bus ignored until the next START.
        wb = wr_cnt; ob = oe_cnt;
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h55, a);
        clk_bit(1'b1, s);
        clk_bit(1'b1, s);
        clk_bit(1'b0, s);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        check("m_reg_addr", {24'd0, reg_addr}, 32'h00);
        check("m_busy", {31'd0, busy}, 32'd0);
        ob = oe_cnt;
        for (int i = 0; i < 5; i++) clk_bit(1'b0, s);
        clk_bit(1'b1, s);
        check("m_no_ack", {31'd0, s}, 32'd1);
        write_byte(8'h84, a);
        check("m_addr_ignored", {31'd0, a}, 32'd0);
        i2c_stop();
        check("m_oe_cycles", oe_cnt - ob, 32'd0);
        check("m_wr_count", wr_cnt - wb, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
